// File: rtl/alu_csr_responder.sv
`default_nettype none
// ============================================================================
//  Module   : alu_csr_responder
//  Brief    : Responder side of the CSR_ALU handshake. Latches opcode and
//             operands, runs a fixed-latency computation on start, then holds
//             the result until the initiator's acknowledge completes.
//  Options  : `define ALU_DIV_EN adds an iterative restoring divider for
//             opcodes 11..14 (DIV, DIVU, REM, REMU). Without it those opcodes
//             return 0 with LATENCY timing.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_csr_responder #(
    parameter int ALUOPBITS   = 4,
    parameter int ALUDATABITS = 32,
    parameter int LATENCY     = 3,
    parameter int MUL_LATENCY = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ALUOPBITS-1:0]   ALUOP,
    input  logic [ALUDATABITS-1:0] OP1,
    input  logic [ALUDATABITS-1:0] OP2,
    input  logic [2:0]             CSR_ALU_IN,
    output logic [2:0]             CSR_ALU_OUT,
    output logic [ALUDATABITS-1:0] OP3
);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_LATCHED = 3'd1;
    localparam logic [2:0] c_ST_BUSY    = 3'd2;
    localparam logic [2:0] c_ST_DONE    = 3'd3;
    localparam logic [2:0] c_ST_ACKED   = 3'd4;

    // Wide enough for the divider's 32-step count as well as the 1..15 latencies
    localparam int c_CNT_W = 6;
    localparam logic [c_CNT_W-1:0] c_LAT_LOAD = c_CNT_W'(LATENCY - 1);
    localparam logic [c_CNT_W-1:0] c_MUL_LOAD = c_CNT_W'(MUL_LATENCY - 1);

    localparam logic [ALUOPBITS-1:0] c_OP_ADD  = ALUOPBITS'(0);
    localparam logic [ALUOPBITS-1:0] c_OP_SUB  = ALUOPBITS'(1);
    localparam logic [ALUOPBITS-1:0] c_OP_AND  = ALUOPBITS'(2);
    localparam logic [ALUOPBITS-1:0] c_OP_OR   = ALUOPBITS'(3);
    localparam logic [ALUOPBITS-1:0] c_OP_XOR  = ALUOPBITS'(4);
    localparam logic [ALUOPBITS-1:0] c_OP_SLL  = ALUOPBITS'(5);
    localparam logic [ALUOPBITS-1:0] c_OP_SRL  = ALUOPBITS'(6);
    localparam logic [ALUOPBITS-1:0] c_OP_SRA  = ALUOPBITS'(7);
    localparam logic [ALUOPBITS-1:0] c_OP_SLT  = ALUOPBITS'(8);
    localparam logic [ALUOPBITS-1:0] c_OP_SLTU = ALUOPBITS'(9);
    localparam logic [ALUOPBITS-1:0] c_OP_MUL  = ALUOPBITS'(10);
`ifdef ALU_DIV_EN
    localparam logic [ALUOPBITS-1:0] c_OP_DIV  = ALUOPBITS'(11);
    localparam logic [ALUOPBITS-1:0] c_OP_DIVU = ALUOPBITS'(12);
    localparam logic [ALUOPBITS-1:0] c_OP_REM  = ALUOPBITS'(13);
    localparam logic [ALUOPBITS-1:0] c_OP_REMU = ALUOPBITS'(14);
    // One quotient bit per step, then the zero-count cycle applies sign fix
    localparam logic [c_CNT_W-1:0]   c_DIV_LOAD = c_CNT_W'(ALUDATABITS);
`endif

    logic [2:0]             state_q, state_d;
    logic [2:0]             out_q, out_d;
    logic [c_CNT_W-1:0]     cnt_q, w_cnt_load;
    logic [ALUOPBITS-1:0]   aluop_q;
    logic [ALUDATABITS-1:0] op1_q, op2_q, op3_q;
    logic [ALUDATABITS-1:0] w_result;

    logic w_latch, w_start, w_finish;

    assign w_latch  = (state_q == c_ST_IDLE)    && CSR_ALU_IN[1];
    assign w_start  = (state_q == c_ST_LATCHED) && CSR_ALU_IN[2];
    assign w_finish = (state_q == c_ST_BUSY)    && (cnt_q == '0);

`ifdef ALU_DIV_EN
    logic [ALUDATABITS-1:0] quo_q, rem_q, dsr_q;
    logic                   qneg_q, rneg_q;
    logic                   w_is_div, w_is_sdiv;
    logic [ALUDATABITS:0]   w_rem_sh;
    logic [ALUDATABITS-1:0] w_rem_sub, w_div_quo, w_div_rem;
    logic                   w_ge;

    assign w_is_div  = (aluop_q == c_OP_DIV) || (aluop_q == c_OP_DIVU) ||
                       (aluop_q == c_OP_REM) || (aluop_q == c_OP_REMU);
    assign w_is_sdiv = (aluop_q == c_OP_DIV) || (aluop_q == c_OP_REM);
    assign w_rem_sh  = {rem_q, quo_q[ALUDATABITS-1]};
    assign w_ge      = w_rem_sh >= {1'b0, dsr_q};
    // Partial remainder always stays below the divisor, so the low bits suffice
    assign w_rem_sub = w_rem_sh[ALUDATABITS-1:0] - dsr_q;
    // Divide by zero returns all-ones quotient and the dividend as remainder
    assign w_div_quo = (op2_q == '0) ? '1    : (qneg_q ? -quo_q : quo_q);
    assign w_div_rem = (op2_q == '0) ? op1_q : (rneg_q ? -rem_q : rem_q);
`endif

    // Counter reload value depends on the latched opcode's class
    always_comb begin
        w_cnt_load = (aluop_q == c_OP_MUL) ? c_MUL_LOAD : c_LAT_LOAD;
`ifdef ALU_DIV_EN
        if (w_is_div) w_cnt_load = c_DIV_LOAD;
`endif
    end

    // Result of the latched operands, captured into OP3 on the finishing cycle
    always_comb begin
        w_result = '0;
        case (aluop_q)
            c_OP_ADD:  w_result = op1_q + op2_q;
            c_OP_SUB:  w_result = op1_q - op2_q;
            c_OP_AND:  w_result = op1_q & op2_q;
            c_OP_OR:   w_result = op1_q | op2_q;
            c_OP_XOR:  w_result = op1_q ^ op2_q;
            c_OP_SLL:  w_result = op1_q << op2_q[4:0];
            c_OP_SRL:  w_result = op1_q >> op2_q[4:0];
            c_OP_SRA:  w_result = $unsigned($signed(op1_q) >>> op2_q[4:0]);
            c_OP_SLT:  w_result = {{(ALUDATABITS-1){1'b0}}, ($signed(op1_q) < $signed(op2_q))};
            c_OP_SLTU: w_result = {{(ALUDATABITS-1){1'b0}}, (op1_q < op2_q)};
            c_OP_MUL:  w_result = op1_q * op2_q;
`ifdef ALU_DIV_EN
            c_OP_DIV, c_OP_DIVU: w_result = w_div_quo;
            c_OP_REM, c_OP_REMU: w_result = w_div_rem;
`endif
            default:   w_result = '0;
        endcase
    end

    // Handshake next-state: only the strobe relevant to the current state counts
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE:    if (CSR_ALU_IN[1])  state_d = c_ST_LATCHED;
            c_ST_LATCHED: if (CSR_ALU_IN[2])  state_d = c_ST_BUSY;
            c_ST_BUSY:    if (cnt_q == '0)    state_d = c_ST_DONE;
            c_ST_DONE:    if (CSR_ALU_IN[0])  state_d = c_ST_ACKED;
            c_ST_ACKED:   if (!CSR_ALU_IN[0]) state_d = c_ST_IDLE;
            default:                          state_d = c_ST_IDLE;
        endcase
    end

    // Status flags decoded from the upcoming state so they register alongside it
    always_comb begin
        out_d = 3'b000;
        case (state_d)
            c_ST_IDLE:    out_d = 3'b001;
            c_ST_LATCHED: out_d = 3'b010;
            c_ST_DONE:    out_d = 3'b100;
            default:      out_d = 3'b000;
        endcase
    end

    // State, counter, operand latches, result register and divider datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_ST_IDLE;
            out_q   <= 3'b001;
            cnt_q   <= '0;
            aluop_q <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            op3_q   <= '0;
`ifdef ALU_DIV_EN
            quo_q   <= '0;
            rem_q   <= '0;
            dsr_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            if (w_latch) begin
                aluop_q <= ALUOP;
                op1_q   <= OP1;
                op2_q   <= OP2;
            end
            if (w_start) begin
                cnt_q <= w_cnt_load;
            end else if ((state_q == c_ST_BUSY) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (w_finish) begin
                op3_q <= w_result;
            end
`ifdef ALU_DIV_EN
            if (w_start) begin
                // Work on magnitudes; signs are reapplied on the final cycle
                quo_q  <= (w_is_sdiv && op1_q[ALUDATABITS-1]) ? -op1_q : op1_q;
                dsr_q  <= (w_is_sdiv && op2_q[ALUDATABITS-1]) ? -op2_q : op2_q;
                rem_q  <= '0;
                qneg_q <= w_is_sdiv && (op1_q[ALUDATABITS-1] ^ op2_q[ALUDATABITS-1]);
                rneg_q <= w_is_sdiv && op1_q[ALUDATABITS-1];
            end else if (w_is_div && (state_q == c_ST_BUSY) && (cnt_q != '0)) begin
                rem_q <= w_ge ? w_rem_sub : w_rem_sh[ALUDATABITS-1:0];
                quo_q <= {quo_q[ALUDATABITS-2:0], w_ge};
            end
`endif
        end
    end

    assign CSR_ALU_OUT = out_q;
    assign OP3         = op3_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_csr_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_csr_responder
//  Brief    : Directed scoreboard bench for alu_csr_responder. Stimulus pushes
//             expected result and done cycle; a monitor pops on each rising
//             done flag. Honours ALU_DIV_EN for the divider vectors.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_csr_responder;

    localparam int c_LAT  = 3;
    localparam int c_MLAT = 6;
    localparam int c_DLAT = 33;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ALUOP;
    logic [31:0] OP1, OP2, OP3;
    logic [2:0]  CSR_ALU_IN, CSR_ALU_OUT;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic done_prev = 1'b0;

    alu_csr_responder #(
        .ALUOPBITS  (4),
        .ALUDATABITS(32),
        .LATENCY    (c_LAT),
        .MUL_LATENCY(c_MLAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ALUOP      (ALUOP),
        .OP1        (OP1),
        .OP2        (OP2),
        .CSR_ALU_IN (CSR_ALU_IN),
        .CSR_ALU_OUT(CSR_ALU_OUT),
        .OP3        (OP3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: compare result and timing on every rising done flag
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            done_prev = 1'b0;
        end else begin
            if (CSR_ALU_OUT[2] && !done_prev) begin
                if (sb.size() == 0) begin
                    check("unexpected done", 32'(CSR_ALU_OUT), 32'h0);
                end else begin
                    e = sb.pop_front();
                    check("result", OP3, e.res);
                    check("done cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            done_prev = CSR_ALU_OUT[2];
        end
    end

    // Latch, start (with scrambled operands and IN[1] still high), optionally abort
    task automatic txn(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat,
                       input bit abort);
        exp_t e;
        bit   seen;
        @(posedge clk); #1;
        ALUOP = op; OP1 = a; OP2 = b; CSR_ALU_IN = 3'b010;
        @(posedge clk); #1;
        CSR_ALU_IN = 3'b000; ALUOP = ~op; OP1 = ~a; OP2 = ~b;
        check({name, " latched"}, 32'(CSR_ALU_OUT), 32'h2);
        @(posedge clk); #1;
        CSR_ALU_IN = 3'b110;
        if (!abort) begin
            e.res = exp;
            e.cyc = cyc + 1 + lat;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        CSR_ALU_IN = 3'b000; OP1 = a ^ 32'h5A5A_5A5A; OP2 = b + 32'd3; ALUOP = op + 4'd1;
        check({name, " busy"}, 32'(CSR_ALU_OUT), 32'h0);
        if (abort) begin
            @(posedge clk); #1;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            check({name, " abort out"}, 32'(CSR_ALU_OUT), 32'h1);
            check({name, " abort op3"}, OP3, 32'h0);
        end else begin
            seen = 1'b0;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (CSR_ALU_OUT[2] === 1'b1) begin
                    seen = 1'b1;
                    break;
                end
            end
            if (!seen) begin
                n_checks++;
                $display("FAIL %s timeout: done never rose within 60 cycles", name);
                sb.delete();
            end else begin
                @(posedge clk); #1;
                CSR_ALU_IN = 3'b001;
                repeat (3) @(posedge clk);
                #1;
                check({name, " ack held"}, 32'(CSR_ALU_OUT), 32'h0);
                check({name, " op3 held"}, OP3, exp);
                CSR_ALU_IN = 3'b000;
                @(posedge clk); #1;
                check({name, " idle"}, 32'(CSR_ALU_OUT), 32'h1);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ALUOP = '0; OP1 = '0; OP2 = '0; CSR_ALU_IN = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset out", 32'(CSR_ALU_OUT), 32'h1);
        check("reset op3", OP3, 32'h0);
        // Stray strobes in IDLE are ignored
        CSR_ALU_IN = 3'b100;
        @(posedge clk); #1;
        check("idle ignores start", 32'(CSR_ALU_OUT), 32'h1);
        CSR_ALU_IN = 3'b001;
        @(posedge clk); #1;
        check("idle ignores ack", 32'(CSR_ALU_OUT), 32'h1);
        CSR_ALU_IN = 3'b000;

        txn("add",   4'd0,  32'd5,          32'd7,          32'd12,         c_LAT,  1'b0);
        txn("mulab", 4'd10, 32'd7,          32'd6,          32'd0,          c_MLAT, 1'b1);
        txn("sub",   4'd1,  32'd0,          32'd1,          32'hFFFF_FFFF,  c_LAT,  1'b0);
        txn("and",   4'd2,  32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  c_LAT,  1'b0);
        txn("or",    4'd3,  32'h0000_F0F0,  32'h0000_FF00,  32'h0000_FFF0,  c_LAT,  1'b0);
        txn("xor",   4'd4,  32'h0000_F0F0,  32'h0000_FF00,  32'h0000_0FF0,  c_LAT,  1'b0);
        txn("sll",   4'd5,  32'd1,          32'h0000_0024,  32'h0000_0010,  c_LAT,  1'b0);
        txn("srl",   4'd6,  32'h8000_0000,  32'd4,          32'h0800_0000,  c_LAT,  1'b0);
        txn("sra",   4'd7,  32'h8000_0000,  32'd31,         32'hFFFF_FFFF,  c_LAT,  1'b0);
        txn("slt",   4'd8,  32'hFFFF_FFFF,  32'd1,          32'd1,          c_LAT,  1'b0);
        txn("sltu",  4'd9,  32'hFFFF_FFFF,  32'd1,          32'd0,          c_LAT,  1'b0);
        txn("mul0",  4'd10, 32'h0001_0000,  32'h0001_0000,  32'd0,          c_MLAT, 1'b0);
        txn("mul",   4'd10, 32'd7,          32'd6,          32'd42,         c_MLAT, 1'b0);
        txn("op15",  4'd15, 32'd9,          32'd9,          32'd0,          c_LAT,  1'b0);
`ifdef ALU_DIV_EN
        txn("div",   4'd11, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  c_DLAT, 1'b0);
        txn("rem",   4'd13, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  c_DLAT, 1'b0);
        txn("divu0", 4'd12, 32'd5,          32'd0,          32'hFFFF_FFFF,  c_DLAT, 1'b0);
        txn("remu",  4'd14, 32'd100,        32'd7,          32'd2,          c_DLAT, 1'b0);
        txn("divov", 4'd11, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  c_DLAT, 1'b0);
`else
        txn("op11",  4'd11, 32'hFFFF_FFF9,  32'd2,          32'd0,          c_LAT,  1'b0);
        txn("op14",  4'd14, 32'd100,        32'd7,          32'd0,          c_LAT,  1'b0);
`endif
        repeat (2) @(posedge clk);
        #1;
        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
